// File: rtl/gcn_layer_sequencer_pkg.sv
// Shared types and defaults for the GCN layer sequencer slice.
package gcn_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRANS_CLR = 3'd1,
    TRANS_RUN = 3'd2,
    COMB_CLR  = 3'd3,
    COMB_RUN  = 3'd4,
    DONE      = 3'd5,
    ERROR     = 3'd6,
    ABORT     = 3'd7
  } seq_state_t;

  localparam int DEF_NUM_LAYERS     = 2;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_CYCLE_CNT_W    = 32;

  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/gcn_layer_sequencer_if.sv
// Control/status bundle between the run controller (master) and host/engines (slave).
interface gcn_layer_sequencer_if #(
  parameter int LAYER_W     = 1,
  parameter int CYCLE_CNT_W = 32
);

  logic                   start;
  logic                   abort;
  logic                   trans_done;
  logic                   comb_done;
  logic                   trans_clear;
  logic                   trans_start;
  logic                   comb_clear;
  logic                   comb_start;
  logic                   mem_sel;
  logic [LAYER_W-1:0]     layer_idx;
  logic                   busy;
  logic                   done;
  logic                   error;
  logic [CYCLE_CNT_W-1:0] cycle_count;

  modport master (
    input  start, abort, trans_done, comb_done,
    output trans_clear, trans_start, comb_clear, comb_start, mem_sel,
    output layer_idx, busy, done, error, cycle_count
  );

  modport slave (
    output start, abort, trans_done, comb_done,
    input  trans_clear, trans_start, comb_clear, comb_start, mem_sel,
    input  layer_idx, busy, done, error, cycle_count
  );

endinterface

// File: rtl/gcn_layer_sequencer_watchdog.sv
// Per-pass watchdog: counts cycles spent in a RUN state, flags the last allowed cycle.
module gcn_watchdog
  import gcn_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int W              = clog2_min1(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  // Expiry marks the TIMEOUT_CYCLES-th RUN cycle; the sequencer leaves the state on it.
  assign o_expired = i_enable && (r_count == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/gcn_layer_sequencer.sv
// Run controller: sequences transformation then combination pass per layer,
// steers the shared read port, and supervises each pass with a watchdog.
module gcn_layer_sequencer
  import gcn_pkg::*;
#(
  parameter int NUM_LAYERS     = DEF_NUM_LAYERS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CYCLE_CNT_W    = DEF_CYCLE_CNT_W,
  parameter int LAYER_W        = clog2_min1(NUM_LAYERS)
) (
  input  logic                  clk,
  input  logic                  reset,
  gcn_layer_sequencer_if.master bus
);

  seq_state_t             r_state;
  seq_state_t             w_next_state;
  logic                   w_accept;
  logic                   w_layer_inc;
  logic                   w_last_layer;
  logic                   w_busy_state;
  logic                   w_wd_clear;
  logic                   w_wd_enable;
  logic                   w_wd_expired;

  logic [LAYER_W-1:0]     r_layer_idx;
  logic [CYCLE_CNT_W-1:0] r_cycle_count;
  logic                   r_trans_clear;
  logic                   r_trans_start;
  logic                   r_comb_clear;
  logic                   r_comb_start;
  logic                   r_mem_sel;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_error;

  assign w_last_layer = (r_layer_idx == LAYER_W'(NUM_LAYERS - 1));
  assign w_wd_clear   = (r_state == TRANS_CLR) || (r_state == COMB_CLR);
  assign w_wd_enable  = (r_state == TRANS_RUN) || (r_state == COMB_RUN);
  assign w_busy_state = w_wd_clear || w_wd_enable;

  gcn_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_wd_clear),
    .i_enable  (w_wd_enable),
    .o_expired (w_wd_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Abort outranks everything; within a RUN state the engine's done outranks expiry.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_layer_inc  = 1'b0;
    if (bus.abort && (r_state != IDLE) && (r_state != ABORT)) begin
      w_next_state = ABORT;
    end else begin
      case (r_state)
        IDLE, DONE, ERROR: begin
          if (bus.start) begin
            w_next_state = TRANS_CLR;
            w_accept     = 1'b1;
          end else begin
            w_next_state = r_state;
          end
        end
        TRANS_CLR: w_next_state = TRANS_RUN;
        TRANS_RUN: begin
          if (bus.trans_done) begin
            w_next_state = COMB_CLR;
          end else if (w_wd_expired) begin
            w_next_state = ERROR;
          end else begin
            w_next_state = TRANS_RUN;
          end
        end
        COMB_CLR: w_next_state = COMB_RUN;
        COMB_RUN: begin
          if (bus.comb_done) begin
            if (w_last_layer) begin
              w_next_state = DONE;
            end else begin
              w_next_state = TRANS_CLR;
              w_layer_inc  = 1'b1;
            end
          end else if (w_wd_expired) begin
            w_next_state = ERROR;
          end else begin
            w_next_state = COMB_RUN;
          end
        end
        ABORT:   w_next_state = IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_layer_idx <= '0;
    end else if (w_accept) begin
      r_layer_idx <= '0;
    end else if (w_layer_inc) begin
      r_layer_idx <= r_layer_idx + LAYER_W'(1);
    end else begin
      r_layer_idx <= r_layer_idx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycle_count <= '0;
    end else if (w_accept) begin
      r_cycle_count <= '0;
    end else if (w_busy_state && (r_cycle_count != {CYCLE_CNT_W{1'b1}})) begin
      r_cycle_count <= r_cycle_count + CYCLE_CNT_W'(1);
    end else begin
      r_cycle_count <= r_cycle_count;
    end
  end

  // Outputs are registered from the next state so they line up with r_state exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_trans_clear <= 1'b0;
      r_trans_start <= 1'b0;
      r_comb_clear  <= 1'b0;
      r_comb_start  <= 1'b0;
      r_mem_sel     <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_trans_clear <= (w_next_state == TRANS_CLR) || (w_next_state == ABORT);
      r_trans_start <= (w_next_state == TRANS_RUN);
      r_comb_clear  <= (w_next_state == COMB_CLR) || (w_next_state == ABORT);
      r_comb_start  <= (w_next_state == COMB_RUN);
      r_mem_sel     <= (w_next_state == COMB_CLR) || (w_next_state == COMB_RUN);
      r_busy        <= (w_next_state == TRANS_CLR) || (w_next_state == TRANS_RUN) ||
                       (w_next_state == COMB_CLR)  || (w_next_state == COMB_RUN);
      r_done        <= (w_next_state == DONE);
      r_error       <= (w_next_state == ERROR);
    end
  end

  assign bus.trans_clear = r_trans_clear;
  assign bus.trans_start = r_trans_start;
  assign bus.comb_clear  = r_comb_clear;
  assign bus.comb_start  = r_comb_start;
  assign bus.mem_sel     = r_mem_sel;
  assign bus.layer_idx   = r_layer_idx;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.error       = r_error;
  assign bus.cycle_count = r_cycle_count;

endmodule
